// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
// Receive-side checker for a VGA pixel stream. Recovers line/frame timing from
// the hsync/vsync pulses, measures line/frame totals and sync widths, declares
// lock once LOCK_FRAMES consecutive frames match the expected timing, recovers
// active-area x/y and counts non-black active pixels per frame.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_pix_en                 one-clk pixel strobe; all sampling happens on it
//   i_hsync, i_vsync         active-high sync pulses
//   i_red/i_green/i_blue     4-bit pixel colour
//   o_h_total/o_h_sync_width last measured samples per line / hsync width
//   o_v_total/o_v_sync_width last measured lines per frame / vsync width
//   o_locked                 timing matches parameters
//   o_frame_done             one-clk pulse per measured frame end
//   o_pixel_valid, o_x, o_y  locked active-area sample and its coordinates
//   o_lit_count              non-black active pixels in last completed frame
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 514,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_en,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [3:0]  i_red,
    input  logic [3:0]  i_green,
    input  logic [3:0]  i_blue,
    output logic [15:0] o_h_total,
    output logic [15:0] o_h_sync_width,
    output logic [15:0] o_v_total,
    output logic [15:0] o_v_sync_width,
    output logic        o_locked,
    output logic        o_frame_done,
    output logic        o_pixel_valid,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic [18:0] o_lit_count
);

    localparam logic [15:0] LP_H_TOTAL     = 16'(H_TOTAL);
    localparam logic [15:0] LP_H_SYNC      = 16'(H_SYNC);
    localparam logic [15:0] LP_H_ACT_START = 16'(H_ACT_START);
    localparam logic [15:0] LP_H_ACT_END   = 16'(H_ACT_END);
    localparam logic [15:0] LP_V_TOTAL     = 16'(V_TOTAL);
    localparam logic [15:0] LP_V_SYNC      = 16'(V_SYNC);
    localparam logic [15:0] LP_V_ACT_START = 16'(V_ACT_START);
    localparam logic [15:0] LP_V_ACT_END   = 16'(V_ACT_END);
    localparam logic [15:0] LP_H_WDOG      = 16'(2 * H_TOTAL);
    localparam logic [7:0]  LP_LOCK_FRAMES = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_good_cnt;
    logic [7:0]  w_good_cnt_next;

    logic        r_prev_hsync;
    logic        r_prev_vsync;
    logic [15:0] r_h_cnt;
    logic [15:0] r_v_cnt;
    logic        r_h_armed;
    logic        r_v_armed;
    logic        r_h_err;
    logic [18:0] r_lit_acc;
    logic [15:0] r_h_total;
    logic [15:0] r_h_sync_width;
    logic [15:0] r_v_total;
    logic [15:0] r_v_sync_width;
    logic        r_frame_done;
    logic        r_pixel_valid;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [18:0] r_lit_count;

    logic        w_h_rise;
    logic        w_h_fall;
    logic        w_v_rise;
    logic        w_v_fall;
    logic [15:0] w_h_cnt_inc;
    logic [15:0] w_v_cnt_inc;
    logic [15:0] w_h_cnt_next;
    logic [15:0] w_v_cnt_next;
    logic        w_h_err_now;
    logic        w_frame_end;
    logic        w_frame_good;
    logic        w_wdog;
    logic        w_active;
    logic        w_lit;

    // Edges are only meaningful on pixel-strobe samples, so gate them here.
    assign w_h_rise = i_pix_en &  i_hsync & ~r_prev_hsync;
    assign w_h_fall = i_pix_en & ~i_hsync &  r_prev_hsync;
    assign w_v_rise = i_pix_en &  i_vsync & ~r_prev_vsync;
    assign w_v_fall = i_pix_en & ~i_vsync &  r_prev_vsync;

    assign w_h_cnt_inc  = (r_h_cnt == 16'hFFFF) ? r_h_cnt : r_h_cnt + 16'd1;
    assign w_v_cnt_inc  = (r_v_cnt == 16'hFFFF) ? r_v_cnt : r_v_cnt + 16'd1;
    assign w_h_cnt_next = w_h_rise ? 16'd0 : w_h_cnt_inc;
    // A vsync rise coinciding with an hsync rise restarts the frame at line 0.
    assign w_v_cnt_next = w_v_rise ? 16'd0 : (w_h_rise ? w_v_cnt_inc : r_v_cnt);

    // Include this sample's hsync error so a bad last line spoils its own frame.
    assign w_h_err_now  = r_h_err
                        | (w_h_rise & r_h_armed & (w_h_cnt_inc != LP_H_TOTAL))
                        | (w_h_fall & r_h_armed & (w_h_cnt_inc != LP_H_SYNC));
    assign w_frame_end  = w_v_rise & r_v_armed;
    assign w_frame_good = ~w_h_err_now & (w_v_cnt_inc == LP_V_TOTAL)
                        & (r_v_sync_width == LP_V_SYNC);
    // Missing hsync for two line periods means the stream is gone.
    assign w_wdog       = i_pix_en & (w_h_cnt_next >= LP_H_WDOG);

    assign w_active = (w_h_cnt_next >= LP_H_ACT_START) & (w_h_cnt_next <= LP_H_ACT_END)
                    & (w_v_cnt_next >= LP_V_ACT_START) & (w_v_cnt_next <= LP_V_ACT_END);
    assign w_lit    = |{i_red, i_green, i_blue};

    // Lock state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_good_cnt <= w_good_cnt_next;
        end
    end

    // Lock next-state: qualify frames at each measured frame end.
    always_comb begin
        w_state_next    = r_state;
        w_good_cnt_next = r_good_cnt;
        if (w_wdog) begin
            w_state_next    = ST_SEARCH;
            w_good_cnt_next = 8'd0;
        end else if (w_v_rise) begin
            case (r_state)
                ST_SEARCH: begin
                    w_state_next    = ST_MEASURE;
                    w_good_cnt_next = 8'd0;
                end
                ST_MEASURE: begin
                    if (w_frame_end && w_frame_good) begin
                        w_good_cnt_next = r_good_cnt + 8'd1;
                        if ((r_good_cnt + 8'd1) >= LP_LOCK_FRAMES) begin
                            w_state_next = ST_LOCKED;
                        end else begin
                            w_state_next = ST_MEASURE;
                        end
                    end else if (w_frame_end) begin
                        w_good_cnt_next = 8'd0;
                    end else begin
                        w_good_cnt_next = r_good_cnt;
                    end
                end
                ST_LOCKED: begin
                    if (w_frame_end && !w_frame_good) begin
                        w_state_next    = ST_MEASURE;
                        w_good_cnt_next = 8'd0;
                    end else begin
                        w_state_next    = ST_LOCKED;
                    end
                end
                default: begin
                    w_state_next    = ST_SEARCH;
                    w_good_cnt_next = 8'd0;
                end
            endcase
        end else begin
            w_state_next    = r_state;
            w_good_cnt_next = r_good_cnt;
        end
    end

    // Timing counters, measurements, lit accumulator and pixel outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_hsync   <= 1'b0;
            r_prev_vsync   <= 1'b0;
            r_h_cnt        <= 16'd0;
            r_v_cnt        <= 16'd0;
            r_h_armed      <= 1'b0;
            r_v_armed      <= 1'b0;
            r_h_err        <= 1'b0;
            r_lit_acc      <= 19'd0;
            r_h_total      <= 16'd0;
            r_h_sync_width <= 16'd0;
            r_v_total      <= 16'd0;
            r_v_sync_width <= 16'd0;
            r_frame_done   <= 1'b0;
            r_pixel_valid  <= 1'b0;
            r_x            <= 16'd0;
            r_y            <= 16'd0;
            r_lit_count    <= 19'd0;
        end else begin
            r_frame_done <= 1'b0;
            if (i_pix_en) begin
                r_prev_hsync <= i_hsync;
                r_prev_vsync <= i_vsync;
                r_h_cnt      <= w_h_cnt_next;
                r_v_cnt      <= w_v_cnt_next;

                if (w_h_rise) begin
                    if (r_h_armed) begin
                        r_h_total <= w_h_cnt_inc;
                    end
                    r_h_armed <= 1'b1;
                end
                if (w_h_fall && r_h_armed) begin
                    r_h_sync_width <= w_h_cnt_inc;
                end
                if (w_v_fall && r_v_armed) begin
                    r_v_sync_width <= w_v_cnt_next;
                end

                if (w_v_rise) begin
                    r_h_err   <= 1'b0;
                    r_lit_acc <= 19'd0;
                    r_v_armed <= 1'b1;
                    if (r_v_armed) begin
                        r_v_total    <= w_v_cnt_inc;
                        r_lit_count  <= r_lit_acc;
                        r_frame_done <= 1'b1;
                    end
                end else begin
                    r_h_err <= w_h_err_now;
                    if (w_active && w_lit && (r_lit_acc != 19'h7FFFF)) begin
                        r_lit_acc <= r_lit_acc + 19'd1;
                    end
                end

                // Losing the stream forces a fresh arm of both measurements.
                if (w_wdog) begin
                    r_h_armed <= 1'b0;
                    r_v_armed <= 1'b0;
                end

                r_pixel_valid <= (r_state == ST_LOCKED) & w_active;
                if ((r_state == ST_LOCKED) && w_active) begin
                    r_x <= w_h_cnt_next - LP_H_ACT_START;
                    r_y <= w_v_cnt_next - LP_V_ACT_START;
                end
            end
        end
    end

    assign o_h_total      = r_h_total;
    assign o_h_sync_width = r_h_sync_width;
    assign o_v_total      = r_v_total;
    assign o_v_sync_width = r_v_sync_width;
    assign o_locked       = (r_state == ST_LOCKED);
    assign o_frame_done   = r_frame_done;
    assign o_pixel_valid  = r_pixel_valid;
    assign o_x            = r_x;
    assign o_y            = r_y;
    assign o_lit_count    = r_lit_count;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor
// Directed bench for vga_timing_monitor using a scaled-down raster
// (20 samples x 12 lines, 12x8 active area) so whole frames stay short.
module tb_vga_timing_monitor;

    localparam int HT  = 20;
    localparam int HS  = 3;
    localparam int HAS = 5;
    localparam int HAE = 16;
    localparam int VT  = 12;
    localparam int VS  = 2;
    localparam int VAS = 3;
    localparam int VAE = 10;
    localparam int LF  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [15:0] h_total;
    logic [15:0] h_sync_width;
    logic [15:0] v_total;
    logic [15:0] v_sync_width;
    logic        locked;
    logic        frame_done;
    logic        pixel_valid;
    logic [15:0] x;
    logic [15:0] y;
    logic [18:0] lit_count;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    int pv_cnt   = 0;
    int first_x  = -1;
    int first_y  = -1;
    int last_x   = -1;
    int last_y   = -1;
    int fd_before;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE),
        .LOCK_FRAMES(LF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
        .i_hsync(hsync), .i_vsync(vsync),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_h_total(h_total), .o_h_sync_width(h_sync_width),
        .o_v_total(v_total), .o_v_sync_width(v_sync_width),
        .o_locked(locked), .o_frame_done(frame_done),
        .o_pixel_valid(pixel_valid), .o_x(x), .o_y(y),
        .o_lit_count(lit_count)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses away from the active edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel-strobe sample every 4 clocks; records pixel_valid activity.
    task automatic sample(input logic h, input logic v, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        @(negedge clk);
        pix_en = 1'b1; hsync = h; vsync = v; red = r; green = g; blue = b;
        @(negedge clk);
        pix_en = 1'b0;
        if (pixel_valid === 1'b1) begin
            if (pv_cnt == 0) begin
                first_x = int'(x);
                first_y = int'(y);
            end
            last_x = int'(x);
            last_y = int'(y);
            pv_cnt++;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // pat 0: black; 1: all white; 2: first active row blue=1, second red=8.
    task automatic drive_px(input int l, input int s, input int vsw, input int pat);
        logic       act;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        act = (s >= HAS) && (s <= HAE) && (l >= VAS) && (l <= VAE);
        r = 4'h0; g = 4'h0; b = 4'h0;
        if (act) begin
            case (pat)
                1: begin r = 4'hF; g = 4'hF; b = 4'hF; end
                2: begin
                    if (l == VAS) b = 4'h1;
                    else if (l == VAS + 1) r = 4'h8;
                end
                default: ;
            endcase
        end
        sample(s < HS, l < vsw, r, g, b);
    endtask

    task automatic drive_frame(input int vsw, input int long_line, input int long_len, input int pat, input bit skip_first);
        int len;
        for (int l = 0; l < VT; l++) begin
            len = (l == long_line) ? long_len : HT;
            for (int s = 0; s < len; s++) begin
                if (!(skip_first && l == 0 && s == 0)) drive_px(l, s, vsw, pat);
            end
        end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
        red = 4'h0; green = 4'h0; blue = 4'h0;
        repeat (3) @(negedge clk);
        check_val("rst_h_total", 32'(h_total), 0);
        check_val("rst_h_sync_width", 32'(h_sync_width), 0);
        check_val("rst_v_total", 32'(v_total), 0);
        check_val("rst_v_sync_width", 32'(v_sync_width), 0);
        check_val("rst_locked", 32'(locked), 0);
        check_val("rst_frame_done", 32'(frame_done), 0);
        check_val("rst_pixel_valid", 32'(pixel_valid), 0);
        check_val("rst_lit_count", 32'(lit_count), 0);
        rst = 1'b0;

        // Nominal timing: arm at rise 1, good frames at rises 2 and 3 -> lock.
        drive_frame(VS, -1, HT, 1, 1'b0);
        drive_frame(VS, -1, HT, 1, 1'b0);
        check_val("unlocked_before_rise3", 32'(locked), 0);
        drive_frame(VS, -1, HT, 1, 1'b0);
        check_val("locked_after_rise3", 32'(locked), 1);
        pv_cnt = 0;
        drive_frame(VS, -1, HT, 1, 1'b0);
        check_val("nom_h_total", 32'(h_total), HT);
        check_val("nom_h_sync_width", 32'(h_sync_width), HS);
        check_val("nom_v_total", 32'(v_total), VT);
        check_val("nom_v_sync_width", 32'(v_sync_width), VS);
        check_val("nom_frame_done_cnt", 32'(fd_cnt), 3);
        check_val("white_lit_count", 32'(lit_count), 96);
        check_val("pixel_valid_cnt", 32'(pv_cnt), 96);
        check_val("first_x", 32'(first_x), 0);
        check_val("first_y", 32'(first_y), 0);
        check_val("last_x", 32'(last_x), 11);
        check_val("last_y", 32'(last_y), 7);

        // Partial pattern: 12 blue + 12 red active pixels.
        drive_frame(VS, -1, HT, 2, 1'b0);
        check_val("lit_after_white_f4", 32'(lit_count), 96);
        // Last line lengthened to HT+1 while locked.
        drive_frame(VS, VT - 1, HT + 1, 1, 1'b0);
        check_val("pattern_lit_count", 32'(lit_count), 24);
        check_val("still_locked_f6", 32'(locked), 1);
        drive_px(0, 0, VS, 1);
        check_val("long_line_h_total", 32'(h_total), HT + 1);
        check_val("long_line_unlock", 32'(locked), 0);
        check_val("long_line_frame_done", 32'(fd_cnt), 6);
        drive_frame(VS, -1, HT, 1, 1'b1);
        check_val("h_total_restored", 32'(h_total), HT);
        check_val("unlocked_after_1_good", 32'(locked), 0);
        drive_frame(VS, -1, HT, 1, 1'b0);
        check_val("unlocked_before_relock", 32'(locked), 0);
        drive_px(0, 0, VS, 1);
        check_val("relocked_after_2_good", 32'(locked), 1);
        check_val("relock_frame_done", 32'(fd_cnt), 8);
        drive_frame(VS, -1, HT, 1, 1'b1);

        // hsync lost: h_cnt ends the frame at 19, watchdog at 40.
        repeat (20) sample(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        check_val("locked_at_hcnt_39", 32'(locked), 1);
        sample(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        check_val("wdog_unlock_at_40", 32'(locked), 0);
        drive_frame(VS, -1, HT, 1, 1'b0);
        check_val("rearm_no_frame_done", 32'(fd_cnt), 8);
        check_val("unlocked_after_rearm", 32'(locked), 0);
        drive_frame(VS, -1, HT, 1, 1'b0);
        check_val("unlocked_1_good_post_wdog", 32'(locked), 0);
        check_val("fd_after_rearm_frame", 32'(fd_cnt), 9);
        drive_px(0, 0, VS, 1);
        check_val("relock_post_wdog", 32'(locked), 1);

        // vsync three lines wide: every frame bad.
        drive_frame(3, -1, HT, 1, 1'b1);
        check_val("vsync3_width", 32'(v_sync_width), 3);
        drive_frame(3, -1, HT, 1, 1'b0);
        check_val("vsync3_unlock", 32'(locked), 0);
        drive_frame(3, -1, HT, 1, 1'b0);
        check_val("vsync3_still_unlocked", 32'(locked), 0);
        drive_px(0, 0, 3, 1);
        check_val("vsync3_never_locks", 32'(locked), 0);
        check_val("vsync3_v_total", 32'(v_total), VT);

        // Reset mid-frame, between clock edges.
        for (int l = 0; l < 6; l++) begin
            for (int s = 0; s < HT; s++) begin
                if (!(l == 0 && s == 0)) drive_px(l, s, 3, 1);
            end
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_h_total", 32'(h_total), 0);
        check_val("async_rst_v_sync_width", 32'(v_sync_width), 0);
        check_val("async_rst_v_total", 32'(v_total), 0);
        check_val("async_rst_lit_count", 32'(lit_count), 0);
        check_val("async_rst_x", 32'(x), 0);
        check_val("async_rst_y", 32'(y), 0);
        @(negedge clk);
        rst = 1'b0;
        fd_before = fd_cnt;
        drive_frame(VS, -1, HT, 1, 1'b0);
        check_val("post_rst_first_rise_no_fd", 32'(fd_cnt), 32'(fd_before));
        check_val("post_rst_h_total", 32'(h_total), HT);
        drive_frame(VS, -1, HT, 1, 1'b0);
        check_val("post_rst_second_rise_fd", 32'(fd_cnt), 32'(fd_before + 1));
        check_val("post_rst_v_total", 32'(v_total), VT);
        check_val("post_rst_lit_count", 32'(lit_count), 96);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
